// File: rtl/mem_wb_ctrl.sv
// rtl/mem_wb_ctrl.sv - MEM/WB stage controller: data-memory handshake, timeout abort and writeback register
module mem_wb_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        reg_write_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] alu_output,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] Mem_ReadData,
    output logic        stall,
    output logic        wb_valid,
    output logic [1:0]  control_signal,
    output logic [31:0] wb_alu_data,
    output logic [31:0] wb_mem_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        mem_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] SEL_MEM = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] req_cnt;
    logic [4:0]    lat_rd;
    logic          lat_reg_write;
    logic          lat_load;

    logic mem_op;
    logic aligned;
    logic timeout_now;

    assign mem_op      = is_load | is_store;
    assign aligned     = (alu_output[1:0] == 2'b00);
    assign timeout_now = (state == REQ) && !mem_ack && (req_cnt == CNT_LAST);

    // The upstream stage is released on the ack/abort cycle so the next
    // instruction is already presented on the first IDLE cycle.
    always_comb begin
        stall = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                stall = instr_valid & mem_op & aligned;
            end else begin
                stall = ~mem_ack & ~timeout_now;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            req_cnt        <= '0;
            lat_rd         <= 5'd0;
            lat_reg_write  <= 1'b0;
            lat_load       <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= 32'd0;
            mem_wdata      <= 32'd0;
            wb_valid       <= 1'b0;
            control_signal <= SEL_ALU;
            wb_alu_data    <= 32'd0;
            wb_mem_data    <= 32'd0;
            wb_rd          <= 5'd0;
            wb_reg_write   <= 1'b0;
            mem_error      <= 1'b0;
        end else begin
            wb_valid  <= 1'b0;
            mem_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        if (!mem_op) begin
                            wb_valid       <= 1'b1;
                            control_signal <= SEL_ALU;
                            wb_alu_data    <= alu_output;
                            wb_rd          <= rd_in;
                            wb_reg_write   <= reg_write_in && (rd_in != 5'd0);
                        end else if (!aligned) begin
                            wb_valid     <= 1'b1;
                            wb_rd        <= rd_in;
                            wb_reg_write <= 1'b0;
                            mem_error    <= 1'b1;
                        end else begin
                            state         <= REQ;
                            req_cnt       <= '0;
                            mem_req       <= 1'b1;
                            mem_we        <= is_store & ~is_load;
                            mem_addr      <= alu_output;
                            mem_wdata     <= store_data;
                            lat_rd        <= rd_in;
                            lat_reg_write <= reg_write_in;
                            lat_load      <= is_load;
                        end
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_rd    <= lat_rd;
                        if (lat_load) begin
                            control_signal <= SEL_MEM;
                            wb_mem_data    <= Mem_ReadData;
                            wb_reg_write   <= lat_reg_write && (lat_rd != 5'd0);
                        end else begin
                            wb_reg_write <= 1'b0;
                        end
                    end else if (timeout_now) begin
                        state        <= IDLE;
                        mem_req      <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= lat_rd;
                        wb_reg_write <= 1'b0;
                        mem_error    <= 1'b1;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// tb/tb_mem_wb_ctrl.sv - self-checking bench for mem_wb_ctrl with a high-level reference model
module tb_mem_wb_ctrl;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid, is_load, is_store, reg_write_in;
    logic [4:0]  rd_in;
    logic [31:0] alu_output, store_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] Mem_ReadData;
    logic        stall, wb_valid;
    logic [1:0]  control_signal;
    logic [31:0] wb_alu_data, wb_mem_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write, mem_error;

    mem_wb_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .is_load(is_load), .is_store(is_store),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .alu_output(alu_output), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .Mem_ReadData(Mem_ReadData), .stall(stall), .wb_valid(wb_valid),
        .control_signal(control_signal), .wb_alu_data(wb_alu_data), .wb_mem_data(wb_mem_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    int          o_stall, o_req, o_cyc;
    logic        o_stable, o_we;
    logic [31:0] o_addr, o_wdata;

    // Presents one instruction at a negedge and runs it to completion; ends at the
    // negedge where its writeback is visible, leaving the instruction still driven.
    task automatic exec_instr(input logic ld, input logic st, input logic rw, input logic [4:0] rd,
                              input logic [31:0] addr, input logic [31:0] sdata,
                              input int ack_lat, input logic [31:0] rdata);
        instr_valid = 1'b1; is_load = ld; is_store = st; reg_write_in = rw;
        rd_in = rd; alu_output = addr; store_data = sdata; mem_ack = 1'b0;
        o_stall = 0; o_req = 0; o_stable = 1'b1;
        #1 if (stall) o_stall++;
        @(posedge clk); @(negedge clk);
        o_we = mem_we; o_addr = mem_addr; o_wdata = mem_wdata;
        while (mem_req && o_req < 4 * T) begin
            mem_ack = (o_req == ack_lat);
            Mem_ReadData = mem_ack ? rdata : $urandom;
            if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_wdata) o_stable = 1'b0;
            #1 if (stall) o_stall++;
            o_req++;
            @(posedge clk); @(negedge clk);
            mem_ack = 1'b0;
        end
        o_cyc = 1 + o_req;
    endtask

    // Outcome of one instruction derived from the rules: which path it takes and what it must produce.
    function automatic void model(input logic ld, input logic st, input logic rw, input logic [4:0] rd,
                                  input logic [31:0] addr, input int lat,
                                  output int e_stall, output int e_req, output logic e_err,
                                  output logic e_rw, output logic e_issue, output logic e_we);
        logic memop, mis, tout;
        memop   = ld | st;
        mis     = memop && (addr % 4 != 0);
        tout    = memop && !mis && (lat < 0 || lat >= T);
        e_we    = st && !ld;
        e_issue = memop && !mis;
        e_req   = !e_issue ? 0 : (tout ? T : lat + 1);
        e_stall = !e_issue ? 0 : (tout ? T : lat + 1);
        e_err   = mis || tout;
        e_rw    = rw && (rd != 0) && !e_err && !(memop && e_we);
    endfunction

    task automatic test_reset;
        rst = 1'b1; instr_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; reg_write_in = 1'b1;
        rd_in = 5'd7; alu_output = 32'h40; store_data = 32'h0; mem_ack = 1'b0; Mem_ReadData = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== 66'd0) begin
            n_err++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h expected all 0", mem_req, mem_we, mem_addr, mem_wdata); end
        n_cmp++; if ({wb_valid, control_signal, wb_alu_data, wb_mem_data, wb_rd, wb_reg_write, mem_error} !== {1'b0, 2'b01, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_wb: got v=%b cs=%b alu=%h mem=%h rd=%0d rw=%b err=%b expected cs=01 others 0",
                wb_valid, control_signal, wb_alu_data, wb_mem_data, wb_rd, wb_reg_write, mem_error); end
        rst = 1'b0; instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic test_alu;
        exec_instr(1'b0, 1'b0, 1'b1, 5'd5, 32'h0000_1234, 32'h0, -1, 32'h0);
        n_cmp++; if (o_stall !== 0) begin n_err++; $display("FAIL alu_stall: got %0d cycles expected 0", o_stall); end
        n_cmp++; if ({wb_valid, control_signal, wb_alu_data, wb_rd, wb_reg_write} !== {1'b1, 2'b01, 32'h1234, 5'd5, 1'b1}) begin
            n_err++; $display("FAIL alu_wb: got v=%b cs=%b alu=%h rd=%0d rw=%b expected v=1 cs=01 alu=1234 rd=5 rw=1",
                wb_valid, control_signal, wb_alu_data, wb_rd, wb_reg_write); end
        exec_instr(1'b0, 1'b0, 1'b1, 5'd0, 32'h55, 32'h0, -1, 32'h0);
        n_cmp++; if ({wb_valid, wb_reg_write} !== 2'b10) begin
            n_err++; $display("FAIL alu_rd0: got v=%b rw=%b expected v=1 rw=0", wb_valid, wb_reg_write); end
        instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL alu_pulse: got %b expected 0", wb_valid); end
    endtask

    task automatic test_load;
        exec_instr(1'b1, 1'b0, 1'b1, 5'd9, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        n_cmp++; if (o_stall !== 4) begin n_err++; $display("FAIL load_stall: got %0d expected 4", o_stall); end
        n_cmp++; if (o_addr !== 32'h100 || !o_stable || o_we !== 1'b0) begin
            n_err++; $display("FAIL load_req: got addr=%h stable=%b we=%b expected 100 1 0", o_addr, o_stable, o_we); end
        n_cmp++; if ({mem_req, wb_valid, control_signal, wb_mem_data, wb_rd, wb_reg_write} !== {1'b0, 1'b1, 2'b00, 32'hDEADBEEF, 5'd9, 1'b1}) begin
            n_err++; $display("FAIL load_wb: got req=%b v=%b cs=%b data=%h rd=%0d rw=%b expected 0 1 00 deadbeef 9 1",
                mem_req, wb_valid, control_signal, wb_mem_data, wb_rd, wb_reg_write); end
    endtask

    task automatic test_store;
        exec_instr(1'b0, 1'b1, 1'b1, 5'd4, 32'h200, 32'hA5A5A5A5, 0, 32'h0);
        n_cmp++; if (o_we !== 1'b1 || o_wdata !== 32'hA5A5A5A5 || o_addr !== 32'h200) begin
            n_err++; $display("FAIL store_req: got we=%b wdata=%h addr=%h expected 1 a5a5a5a5 200", o_we, o_wdata, o_addr); end
        n_cmp++; if ({wb_valid, wb_reg_write, mem_error} !== 3'b100) begin
            n_err++; $display("FAIL store_wb: got v=%b rw=%b err=%b expected 1 0 0", wb_valid, wb_reg_write, mem_error); end
    endtask

    task automatic test_misaligned;
        exec_instr(1'b1, 1'b0, 1'b1, 5'd6, 32'h102, 32'h0, 0, 32'h0);
        n_cmp++; if (o_stall !== 0 || o_req !== 0) begin
            n_err++; $display("FAIL mis_req: got stall=%0d req=%0d expected 0 0", o_stall, o_req); end
        n_cmp++; if ({wb_valid, wb_reg_write, mem_error} !== 3'b101) begin
            n_err++; $display("FAIL mis_wb: got v=%b rw=%b err=%b expected 1 0 1", wb_valid, wb_reg_write, mem_error); end
        instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (mem_error !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got %b expected 0", mem_error); end
    endtask

    task automatic test_timeout;
        exec_instr(1'b1, 1'b0, 1'b1, 5'd3, 32'h300, 32'h0, -1, 32'h0);
        n_cmp++; if (o_req !== T || !o_stable) begin
            n_err++; $display("FAIL to_req: got %0d cycles stable=%b expected %0d 1", o_req, o_stable, T); end
        n_cmp++; if (o_stall !== T) begin n_err++; $display("FAIL to_stall: got %0d expected %0d", o_stall, T); end
        n_cmp++; if ({mem_req, wb_valid, wb_reg_write, mem_error} !== 4'b0101) begin
            n_err++; $display("FAIL to_wb: got req=%b v=%b rw=%b err=%b expected 0 1 0 1", mem_req, wb_valid, wb_reg_write, mem_error); end
    endtask

    task automatic test_reset_mid_req;
        instr_valid = 1'b1; is_load = 1'b1; is_store = 1'b0; reg_write_in = 1'b1; rd_in = 5'd8; alu_output = 32'h400;
        @(posedge clk); @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rstreq_enter: got %b expected 1", mem_req); end
        instr_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rstreq_stall: got %b expected 0", stall); end
        @(posedge clk); @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; Mem_ReadData = 32'h1111_2222;
        n_cmp++; if ({mem_req, mem_we, mem_addr, mem_wdata, wb_valid, control_signal, wb_rd, wb_reg_write, mem_error} !== {1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 2'b01, 5'd0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL rstreq_vals: got req=%b addr=%h v=%b cs=%b rd=%0d err=%b expected reset values",
                mem_req, mem_addr, wb_valid, control_signal, wb_rd, mem_error); end
        @(posedge clk); @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) begin
            n_cmp++; if ({mem_req, wb_valid, mem_error, wb_mem_data} !== 35'd0) begin
                n_err++; $display("FAIL rstreq_ack: got req=%b v=%b err=%b data=%h expected all 0", mem_req, wb_valid, mem_error, wb_mem_data); end
            @(posedge clk); @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        exec_instr(1'b0, 1'b0, 1'b1, 5'd10, 32'hAAAA_0001, 32'h0, -1, 32'h0);
        exec_instr(1'b0, 1'b0, 1'b1, 5'd11, 32'hBBBB_0002, 32'h0, -1, 32'h0);
        n_cmp++; if ({wb_valid, wb_alu_data, wb_rd, o_cyc} !== {1'b1, 32'hBBBB_0002, 5'd11, 32'd1}) begin
            n_err++; $display("FAIL b2b_alu: got v=%b alu=%h rd=%0d cyc=%0d expected 1 bbbb0002 11 1", wb_valid, wb_alu_data, wb_rd, o_cyc); end
        exec_instr(1'b1, 1'b0, 1'b1, 5'd12, 32'h500, 32'h0, 1, 32'h0BAD_F00D);
        n_cmp++; if (o_cyc !== 3 || wb_mem_data !== 32'h0BAD_F00D) begin
            n_err++; $display("FAIL b2b_load: got cyc=%0d data=%h expected 3 0badf00d", o_cyc, wb_mem_data); end
        exec_instr(1'b0, 1'b0, 1'b1, 5'd13, 32'hCCCC_0003, 32'h0, -1, 32'h0);
        n_cmp++; if ({wb_valid, control_signal, wb_alu_data, o_cyc} !== {1'b1, 2'b01, 32'hCCCC_0003, 32'd1}) begin
            n_err++; $display("FAIL b2b_after_load: got v=%b cs=%b alu=%h cyc=%0d expected 1 01 cccc0003 1", wb_valid, control_signal, wb_alu_data, o_cyc); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 60; i++) begin
            logic ld, st, rw, e_err, e_rw, e_issue, e_we;
            logic [4:0] rd;
            logic [31:0] addr, sd, rdat;
            int lat, sel, e_stall, e_req;
            sel = $urandom_range(0, 9);
            ld = (sel >= 3 && sel <= 5) || sel >= 8;
            st = (sel >= 6 && sel <= 8) || (sel == 9 && $urandom_range(0, 1) == 1);
            rw = $urandom_range(0, 1) == 1;
            rd = 5'($urandom);
            addr = $urandom; sd = $urandom; rdat = $urandom;
            if (sel >= 3 && sel <= 8) addr[1:0] = 2'b00;
            if (sel == 9) addr[1:0] = 2'($urandom_range(1, 3));
            lat = ($urandom_range(0, 11) == 0) ? -1 : $urandom_range(0, 5);
            model(ld, st, rw, rd, addr, lat, e_stall, e_req, e_err, e_rw, e_issue, e_we);
            exec_instr(ld, st, rw, rd, addr, sd, lat, rdat);
            n_cmp++; if (o_stall !== e_stall || o_req !== e_req) begin
                n_err++; $display("FAIL rand_timing[%0d]: got stall=%0d req=%0d expected %0d %0d", i, o_stall, o_req, e_stall, e_req); end
            if (e_issue) begin
                n_cmp++; if (!o_stable || o_we !== e_we || o_addr !== addr || (e_we && o_wdata !== sd)) begin
                    n_err++; $display("FAIL rand_req[%0d]: got stable=%b we=%b addr=%h wdata=%h expected 1 %b %h %h", i, o_stable, o_we, o_addr, o_wdata, e_we, addr, sd); end
            end
            n_cmp++; if ({wb_valid, mem_error, wb_reg_write} !== {1'b1, e_err, e_rw}) begin
                n_err++; $display("FAIL rand_wb[%0d]: got v=%b err=%b rw=%b expected 1 %b %b", i, wb_valid, mem_error, wb_reg_write, e_err, e_rw); end
            if (!e_err && !(e_issue && e_we)) begin
                n_cmp++; if (wb_rd !== rd || control_signal !== (e_issue ? 2'b00 : 2'b01) || (e_issue ? wb_mem_data : wb_alu_data) !== (e_issue ? rdat : addr)) begin
                    n_err++; $display("FAIL rand_data[%0d]: got rd=%0d cs=%b alu=%h mem=%h expected rd=%0d alu/addr=%h mem=%h", i, wb_rd, control_signal, wb_alu_data, wb_mem_data, rd, addr, rdat); end
            end
            if ($urandom_range(0, 1) == 1) begin
                instr_valid = 1'b0;
                @(posedge clk); @(negedge clk);
                n_cmp++; if ({wb_valid, mem_error, mem_req} !== 3'b000) begin
                    n_err++; $display("FAIL rand_pulse[%0d]: got v=%b err=%b req=%b expected 0 0 0", i, wb_valid, mem_error, mem_req); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_load;
        test_store;
        test_misaligned;
        test_timeout;
        test_reset_mid_req;
        test_back_to_back;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mem_wb_ctrl.md
MEM_WB_CTRL -- requirements
Module: mem_wb_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: REQ-state cycles without mem_ack before abort.
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port instr_valid  in  1  MEM-stage instruction present.
REQ-005 SHALL have port is_load  in  1  instruction is word load.
REQ-006 SHALL have port is_store  in  1  instruction is word store.
REQ-007 SHALL have port reg_write_in  in  1  instruction writes rd.
REQ-008 SHALL have port rd_in  in  5  destination register.
REQ-009 SHALL have port alu_output  in  32  ALU result / effective address.
REQ-010 SHALL have port store_data  in  32  store write data.
REQ-011 SHALL have port mem_req  out  1  data-memory request.
REQ-012 SHALL have port mem_we  out  1  1 = write, 0 = read.
REQ-013 SHALL have port mem_addr  out  32  memory address.
REQ-014 SHALL have port mem_wdata  out  32  memory write data.
REQ-015 SHALL have port mem_ack  in  1  memory completion, one-cycle pulse.
REQ-016 SHALL have port Mem_ReadData  in  32  memory read data, valid with mem_ack.
REQ-017 SHALL have port stall  out  1  combinational, hold upstream pipeline.
REQ-018 SHALL have port wb_valid  out  1  one-cycle writeback strobe.
REQ-019 SHALL have port control_signal  out  2  writeback mux select: 2'b01 ALU, 2'b00 memory.
REQ-020 SHALL have port wb_alu_data  out  32  registered ALU result.
REQ-021 SHALL have port wb_mem_data  out  32  registered load data.
REQ-022 SHALL have ports wb_rd out 5 and wb_reg_write out 1  writeback destination and enable.
REQ-023 SHALL have port mem_error  out  1  one-cycle pulse: misaligned access or timeout.

Function
REQ-024 SHALL implement states IDLE and REQ; inputs sampled only in IDLE; mem_ack ignored in IDLE.
REQ-025 IDLE, instr_valid, no mem op: next cycle wb_valid=1, control_signal=01, wb_alu_data=alu_output, wb_rd=rd_in, wb_reg_write=reg_write_in; stall=0; latency 1.
REQ-026 IDLE, instr_valid, is_load or is_store, alu_output[1:0]==0: stall=1 same cycle; next edge enter REQ with mem_req=1, mem_we=is_store&~is_load, mem_addr=alu_output, mem_wdata=store_data, rd/reg_write latched.
REQ-027 is_load and is_store both high: treated as load.
REQ-028 Misaligned (alu_output[1:0]!=0) mem op in IDLE: no request, stall=0; next cycle wb_valid=1, wb_reg_write=0, mem_error=1.
REQ-029 REQ: mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack or timeout; stall=~mem_ack, except 0 on timeout cycle.
REQ-030 REQ with mem_ack: next edge mem_req=0, IDLE, wb_valid=1; load: control_signal=00, wb_mem_data=Mem_ReadData, wb_reg_write=latched reg_write; store: wb_reg_write=0.
REQ-031 REQ cycle counter 0 at entry, +1 per cycle without ack; at count TIMEOUT_CYCLES-1 with no ack: next edge mem_req=0, IDLE, wb_valid=1, wb_reg_write=0, mem_error=1.
REQ-032 wb_reg_write SHALL be forced 0 whenever wb_rd==0.
REQ-033 wb_valid and mem_error SHALL be single-cycle pulses; other wb_* outputs hold until next wb_valid.
REQ-034 Back-to-back: new instruction accepted in the IDLE cycle after completion; no idle bubble beyond that cycle.

Reset
REQ-035 rst high at edge: state IDLE, counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, wb_valid 0, control_signal 01, wb_alu_data 0, wb_mem_data 0, wb_rd 0, wb_reg_write 0, mem_error 0.
REQ-036 stall SHALL be 0 while rst high.
REQ-037 Reset during REQ SHALL abort the access with no wb_valid and no mem_error; mem_ack after reset ignored.

Verification
REQ-038 ALU op alu_output=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid=1, control_signal=01, wb_alu_data=0x1234, wb_rd=5, stall never high.
REQ-039 Load addr 0x100, mem_ack 3 cycles after mem_req, Mem_ReadData=0xDEADBEEF -> stall high 4 cycles, mem_addr stable 0x100, then wb_valid, control_signal=00, wb_mem_data=0xDEADBEEF.
REQ-040 Store addr 0x200, data 0xA5A5A5A5, immediate ack -> mem_we=1, mem_wdata=0xA5A5A5A5, wb_valid with wb_reg_write=0.
REQ-041 Load addr 0x102 -> no mem_req, mem_error pulse, wb_reg_write=0, stall=0.
REQ-042 Load, no mem_ack -> mem_req deasserts after 16 REQ cycles, mem_error=1, wb_reg_write=0; rd=0 ALU op -> wb_reg_write=0.
REQ-043 rst asserted mid-REQ, then mem_ack -> all outputs at reset values, no wb_valid, no mem_error.
